// File: rtl/obi_router_pkg.sv
// Shared definitions for the OBI data router.
//   ERR_RDATA         read data returned for the internal error route
//   DEFAULT_SLV_BASE  default two-slave address map bases (slave i at index i)
//   DEFAULT_SLV_MASK  default two-slave address map compare masks
//   route_width()     bit width needed to encode slaves 0..N-1 plus the error route N
package obi_router_pkg;

    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    localparam logic [1:0][31:0] DEFAULT_SLV_BASE = {32'h1000_0000, 32'h0000_0000};
    localparam logic [1:0][31:0] DEFAULT_SLV_MASK = {32'hF000_0000, 32'hF000_0000};

    // Route ids run 0..num_slv, the top value being the error route.
    function automatic int route_width(input int num_slv);
        return (num_slv > 0) ? $clog2(num_slv + 1) : 1;
    endfunction

endpackage

// File: rtl/obi_route_fifo.sv
// In-order FIFO of route ids for outstanding OBI transactions.
//   clk, rst      clock and asynchronous active-high reset
//   push, data_in write one entry
//   pop           retire the head entry
//   head          entry at the read pointer (valid when count > 0)
//   count         number of stored entries, 0..DEPTH
//   full          count == DEPTH
module obi_route_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // Storage, pointers and occupancy; a simultaneous push and pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/obi_data_router.sv
// OBI data-side router: one core master to NUM_SLV address-decoded slaves.
//   clk, rst                      clock and asynchronous active-high reset
//   m_req/m_we/m_addr/m_wdata/m_be  core request fields
//   m_gnt/m_rvalid/m_err/m_rdata    core grant and in-order response
//   s_req                         per-slave request (one-hot or zero)
//   s_addr/s_wdata/s_we/s_be      broadcast copies of the master fields
//   s_gnt/s_rvalid/s_rdata        per-slave grant, response valid, packed read data
//   spurious                      sticky flag for unexpected slave responses
// Unmapped addresses go to an internal error route that answers with m_err.
module obi_data_router
    import obi_router_pkg::*;
#(
    parameter int                       NUM_SLV  = 2,
    parameter int                       MAX_OUT  = 2,
    parameter logic [NUM_SLV-1:0][31:0] SLV_BASE = DEFAULT_SLV_BASE,
    parameter logic [NUM_SLV-1:0][31:0] SLV_MASK = DEFAULT_SLV_MASK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_req,
    input  logic                    m_we,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    input  logic [3:0]              m_be,
    output logic                    m_gnt,
    output logic                    m_rvalid,
    output logic                    m_err,
    output logic [31:0]             m_rdata,
    output logic [NUM_SLV-1:0]      s_req,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic                    s_we,
    output logic [3:0]              s_be,
    input  logic [NUM_SLV-1:0]      s_gnt,
    input  logic [NUM_SLV-1:0]      s_rvalid,
    input  logic [32*NUM_SLV-1:0]   s_rdata,
    output logic                    spurious
);

    localparam int            RW  = route_width(NUM_SLV);
    localparam int            CW  = $clog2(MAX_OUT + 1);
    localparam logic [RW-1:0] ERR = RW'(NUM_SLV);

    logic [RW-1:0]      sel;
    logic               sel_gnt;
    logic               full;
    logic [CW-1:0]      count;
    logic [RW-1:0]      head;
    logic               push;
    logic               pop;
    logic [NUM_SLV-1:0] rsp_expected;
    logic               spurious_hit;

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_we    = m_we;
    assign s_be    = m_be;

    // Address decode: scanning downward lets the lowest-index hit win.
    always_comb begin
        sel = ERR;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i]) == SLV_BASE[i]) begin
                sel = RW'(i);
            end
        end
    end

    // Request fan-out and grant; the error route grants itself immediately.
    always_comb begin
        sel_gnt = 1'b1;
        s_req   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel == RW'(i)) begin
                sel_gnt  = s_gnt[i];
                s_req[i] = m_req & ~full;
            end
        end
    end

    assign m_gnt = ~full & m_req & sel_gnt;
    assign push  = m_gnt;
    assign pop   = m_rvalid;

    obi_route_fifo #(
        .WIDTH (RW),
        .DEPTH (MAX_OUT)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .data_in (sel),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full)
    );

    // Response mux driven by the head route; only the head slave may answer.
    always_comb begin
        m_rvalid     = 1'b0;
        m_err        = 1'b0;
        m_rdata      = ERR_RDATA;
        rsp_expected = '0;
        if (count != '0) begin
            if (head == ERR) begin
                m_rvalid = 1'b1;
                m_err    = 1'b1;
            end else begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    if (head == RW'(i)) begin
                        rsp_expected[i] = 1'b1;
                        m_rvalid        = s_rvalid[i];
                        m_rdata         = s_rdata[32*i +: 32];
                    end
                end
            end
        end
    end

    assign spurious_hit = |(s_rvalid & ~rsp_expected);

    // Sticky spurious-response flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spurious <= 1'b0;
        end else if (spurious_hit) begin
            spurious <= 1'b1;
        end
    end

endmodule

// File: doc/obi_data_router.md
OBI_DATA_ROUTER -- requirements
Module: obi_data_router

Interface
REQ-001 Parameter NUM_SLV, default 2, number of downstream slave ports (1..8).
REQ-002 Parameter MAX_OUT, default 2, max outstanding master transactions (1..8).
REQ-003 Parameter SLV_BASE, default {32'h1000_0000, 32'h0000_0000}, per-slave base address, slave i at index i.
REQ-004 Parameter SLV_MASK, default {32'hF000_0000, 32'hF000_0000}, per-slave compare mask.
REQ-005 Signal clk, input, 1, sole clock, all state on rising edge.
REQ-006 Signal rst, input, 1, asynchronous active-high reset.
REQ-007 Signals m_req, m_we, input, 1: core request and write enable. m_addr, m_wdata, input, 32: core address and write data. m_be, input, 4: byte enables.
REQ-008 Signals m_gnt, m_rvalid, m_err, output, 1: grant, response valid, error response. m_rdata, output, 32: read data.
REQ-009 Signal s_req, output, NUM_SLV: per-slave request.
REQ-010 Signals s_addr, s_wdata, output, 32; s_we, output, 1; s_be, output, 4: broadcast copies of the master fields.
REQ-011 Signal s_gnt, input, NUM_SLV: per-slave grant. s_rvalid, input, NUM_SLV: per-slave response valid. s_rdata, input, 32*NUM_SLV: packed slave read data, slave i at bits [32i+31:32i].
REQ-012 Signal spurious, output, 1: sticky flag, set when a slave responds with no response expected from it.

Function
REQ-013 Decode is combinational: hit[i] = ((m_addr & SLV_MASK[i]) == SLV_BASE[i]); the lowest-index hit wins; no hit selects the internal error route ERR = NUM_SLV.
REQ-014 s_req[i] = m_req & sel==i & ~full; all other s_req bits are 0.
REQ-015 m_gnt = ~full & m_req & (sel==ERR ? 1 : s_gnt[sel]); ERR requests are granted in the same cycle.
REQ-016 On m_req & m_gnt, the route id (width clog2(NUM_SLV+1)) is pushed into an in-order route FIFO of depth MAX_OUT.
REQ-017 full = (count == MAX_OUT). Grant is blocked when full, even if a pop occurs in the same cycle.
REQ-018 Responses are returned strictly in grant order. The head route h is valid when count > 0.
REQ-019 h < NUM_SLV: m_rvalid = s_rvalid[h], m_rdata = s_rdata[h], m_err = 0.
REQ-020 h == ERR: m_rvalid = 1 and m_err = 1 in the first cycle the entry is at the head, with m_rdata = 32'h0000_0000. This is at least 1 cycle after its grant.
REQ-021 Pop occurs on m_rvalid. Simultaneous push and pop leaves count unchanged.
REQ-022 count is 0 when empty: m_rvalid = 0, m_err = 0, m_rdata = 0.
REQ-023 Slaves shall not assert s_rvalid in their grant cycle; the minimum response latency is 1 cycle.
REQ-024 spurious is set on any s_rvalid[i] with i != h or count == 0. It clears only on rst, and the offending response is dropped.
REQ-025 FIFO pointers wrap modulo MAX_OUT. count saturates in neither direction; push when full and pop when empty are unreachable by construction.

Reset
REQ-026 rst asynchronously clears the FIFO pointers, count and spurious. Registered outputs read 0 while rst is high.
REQ-027 Outstanding transactions are discarded on reset mid-operation. Late slave responses after reset set spurious and are not forwarded.

Structure
REQ-028 Package obi_router_pkg holds: the ERR_RDATA constant (32'h0), the function returning route id width, and the default base/mask localparams.
REQ-029 One sub-module, obi_route_fifo: synchronous FIFO with width and depth parameters, push/pop/head/count/full outputs, and async active-high reset. The decode and response mux stay in obi_data_router.

Verification
REQ-030 Read to 32'h0000_0100, s_gnt[0]=1, s_rvalid[0] 2 cycles later with data 32'hA5A5_0001 -> s_req=2'b01, m_gnt same cycle, m_rdata=32'hA5A5_0001 with m_rvalid, m_err=0.
REQ-031 Back-to-back reads: slave1 (32'h1000_0004), then slave0 (32'h0000_0008), MAX_OUT=2; slave0 rvalid early with slave1 pending -> spurious=1, that response dropped; slave1 response is forwarded first.
REQ-032 Three requests with no responses, MAX_OUT=2 -> third m_gnt=0 and s_req=0 until the first pop, then granted the cycle after the pop.
REQ-033 Unmapped address 32'h2000_0000 with custom map that misses -> m_gnt same cycle, next cycle m_rvalid=1, m_err=1, m_rdata=0, no s_req asserted.
REQ-034 rst pulsed with 2 outstanding, then s_rvalid[1]=1 -> m_rvalid=0, spurious=1, count=0, and the next request is granted normally.
REQ-035 NUM_SLV=4, overlapping masks on slaves 1 and 3 at 32'h3000_0000 -> slave 1 selected, s_req=4'b0010.
